// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM states, buffer entry layout and default NOP word for fetch_unit.
package fetch_pkg;
    localparam logic [31:0] NOP_DEFAULT = 32'hE1A00000;
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] data;
    } entry_t;
endpackage

// File: rtl/fetch_entry.sv
// fetch_entry: one instruction buffer entry with write, invalidate and tag compare.
module fetch_entry
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic        inv_i,
    input  logic [29:0] tag_i,
    input  logic [31:0] data_i,
    input  logic [29:0] cmp_tag_i,
    output entry_t      ent_o,
    output logic        hit_o
);
    entry_t ent_q, ent_d;
    always_comb begin
        ent_d = ent_q;
        if (we_i) ent_d = '{valid: 1'b1, tag: tag_i, data: data_i};
        else if (inv_i) ent_d.valid = 1'b0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) ent_q <= '0;
        else ent_q <= ent_d;
    assign ent_o = ent_q;
    assign hit_o = ent_q.valid && ent_q.tag == cmp_tag_i;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with valid/ack memory handshake and watchdog.
// Define FETCH_PREFETCH_EN to add a second (NXT) entry that prefetches pc+4.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [29:0] addr_q;
    logic        req_q, err_q, pf_q;
    entry_t      cur, nxt;
    logic        cur_hit, nxt_hit, hit, ack, promote, pf_need;

    assign hit       = cur_hit || nxt_hit;
    assign ack       = state_q == BUSY && mem_ack;
    assign stall     = !hit || err_q;
    assign instr     = stall ? NOP_INSTR : (cur_hit ? cur.data : nxt.data);
    assign mem_req   = req_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign fetch_err = err_q;

    fetch_entry u_cur (
        .clk, .reset,
        .we_i     (ack && !pf_q || promote),
        .inv_i    (1'b0),
        .tag_i    (promote ? nxt.tag : addr_q),
        .data_i   (promote ? nxt.data : mem_rdata),
        .cmp_tag_i(pc[31:2]),
        .ent_o    (cur),
        .hit_o    (cur_hit)
    );

`ifdef FETCH_PREFETCH_EN
    assign promote = state_q == IDLE && nxt_hit && !cur_hit;
    assign pf_need = cur_hit && !(nxt.valid && nxt.tag == pc[31:2] + 30'd1);
    fetch_entry u_nxt (
        .clk, .reset,
        .we_i     (ack && pf_q),
        .inv_i    (ack && !pf_q || promote),
        .tag_i    (addr_q),
        .data_i   (mem_rdata),
        .cmp_tag_i(pc[31:2]),
        .ent_o    (nxt),
        .hit_o    (nxt_hit)
    );
`else
    assign promote = 1'b0;
    assign pf_need = 1'b0;
    assign nxt     = '0;
    assign nxt_hit = 1'b0;
`endif

    // The counter check sits one cycle after reaching TIMEOUT so the error lands TIMEOUT+1 cycles after the request.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else case (state_q)
            IDLE:
                if (!hit) begin
                    state_q <= BUSY;
                    req_q   <= 1'b1;
                    addr_q  <= pc[31:2];
                    cnt_q   <= '0;
                    pf_q    <= 1'b0;
                end else if (pf_need) begin
                    state_q <= BUSY;
                    req_q   <= 1'b1;
                    addr_q  <= pc[31:2] + 30'd1;
                    cnt_q   <= '0;
                    pf_q    <= 1'b1;
                end
            BUSY:
                if (mem_ack) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_q <= ERR;
                    req_q   <= 1'b0;
                    err_q   <= 1'b1;
                end else cnt_q <= cnt_q + 8'd1;
            default: ;
        endcase
endmodule
